// File: rtl/i2s_frame_guard.sv
// rtl/i2s_frame_guard.sv - I2S LRCK framing checker with lock detection and data muting
module i2s_frame_guard #(
  parameter int BITS_PER_HALF = 32,
  parameter int LOCK_HALVES   = 8,
  parameter int CNT_W         = 6
) (
  input  logic       BCK,
  input  logic       RST,
  input  logic       LRCK,
  input  logic       DATAIN,
  output logic       LRCK_OUT,
  output logic       DATA_OUT,
  output logic       LOCK,
  output logic       MUTE,
  output logic [7:0] ERR_COUNT,
  output logic       LED1
);

  localparam int GOOD_W = $clog2(LOCK_HALVES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BITS_PER_HALF - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GOOD_W-1:0] GOOD_FIN = GOOD_W'(LOCK_HALVES - 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good;
  logic              lrck_q;

  logic lrck_edge;
  logic lrck_fall;
  logic at_last;
  logic valid_half;
  logic short_half;
  logic long_half;
  logic frame_err;
  logic mute_next;

  assign lrck_edge  = LRCK != lrck_q;
  assign lrck_fall  = lrck_q & ~LRCK;
  assign at_last    = cnt == CNT_LAST;
  assign valid_half = lrck_edge & at_last;
  assign short_half = lrck_edge & (cnt < CNT_LAST);
  // A half that runs past its slot is flagged on the overrun cycle, not at the late edge
  assign long_half  = ~lrck_edge & at_last;
  assign frame_err  = short_half | long_half;

  assign LED1 = ~LOCK;

  // Mute follows the same-cycle decision so the erroneous bit itself is already zeroed
  always_comb begin
    mute_next = MUTE;
    if (state == LOCKED) begin
      if (frame_err) begin
        mute_next = 1'b1;
      end else if (lrck_fall) begin
        mute_next = 1'b0;
      end
    end
  end

  // Framing FSM, half-period counter, error counter and one-BCK output pipeline
  always_ff @(posedge BCK) begin
    if (RST) begin
      state     <= SEARCH;
      cnt       <= '0;
      good      <= '0;
      lrck_q    <= 1'b0;
      LRCK_OUT  <= 1'b0;
      DATA_OUT  <= 1'b0;
      LOCK      <= 1'b0;
      MUTE      <= 1'b1;
      ERR_COUNT <= '0;
    end else begin
      lrck_q   <= LRCK;
      LRCK_OUT <= LRCK;
      MUTE     <= mute_next;
      DATA_OUT <= mute_next ? 1'b0 : DATAIN;

      if (lrck_edge) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        SEARCH: begin
          if (lrck_edge) begin
            state <= ACQUIRE;
            good  <= '0;
          end
        end
        ACQUIRE: begin
          if (frame_err) begin
            good <= '0;
            if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
          end else if (valid_half) begin
            if (good == GOOD_FIN) begin
              state <= LOCKED;
              LOCK  <= 1'b1;
              good  <= '0;
            end else begin
              good <= good + GOOD_W'(1);
            end
          end
        end
        LOCKED: begin
          if (frame_err) begin
            state <= ACQUIRE;
            good  <= '0;
            LOCK  <= 1'b0;
            if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_frame_guard.sv
// tb/tb_i2s_frame_guard.sv - scoreboard bench for i2s_frame_guard
module tb_i2s_frame_guard;

  logic       BCK = 1'b0;
  logic       RST;
  logic       LRCK;
  logic       DATAIN;
  logic       LRCK_OUT;
  logic       DATA_OUT;
  logic       LOCK;
  logic       MUTE;
  logic [7:0] ERR_COUNT;
  logic       LED1;

  i2s_frame_guard dut (
    .BCK      (BCK),
    .RST      (RST),
    .LRCK     (LRCK),
    .DATAIN   (DATAIN),
    .LRCK_OUT (LRCK_OUT),
    .DATA_OUT (DATA_OUT),
    .LOCK     (LOCK),
    .MUTE     (MUTE),
    .ERR_COUNT(ERR_COUNT),
    .LED1     (LED1)
  );

  always #5 BCK = ~BCK;

  typedef struct packed {
    logic       lrck;
    logic       data;
    logic       lock;
    logic       mute;
    logic [7:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_no = 0;
  logic e_lock;
  logic e_mute;
  int   e_err;
  logic lvl;

  // Monitor: one expectation per clock, popped just after the sampling edge
  always @(posedge BCK) begin
    exp_t e;
    exp_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.lrck = LRCK_OUT;
      a.data = DATA_OUT;
      a.lock = LOCK;
      a.mute = MUTE;
      a.err  = ERR_COUNT;
      total++;
      if (a !== e || LED1 !== ~e.lock) begin
        bad++;
        if (bad <= 20)
          $display("FAIL outputs cyc=%0d got lrck=%b data=%b lock=%b mute=%b err=%0d led=%b want lrck=%b data=%b lock=%b mute=%b err=%0d led=%b",
                   cyc_no, a.lrck, a.data, a.lock, a.mute, a.err, LED1,
                   e.lrck, e.data, e.lock, e.mute, e.err, ~e.lock);
      end
      cyc_no++;
    end
  end

  task automatic bump();
    e_err = (e_err < 255) ? e_err + 1 : 255;
  endtask

  task automatic cyc(input logic rst, input logic lr);
    exp_t e;
    @(negedge BCK);
    RST    = rst;
    LRCK   = lr;
    DATAIN = 1'($urandom_range(0, 1));
    if (rst) begin
      e.lrck = 1'b0; e.data = 1'b0; e.lock = 1'b0; e.mute = 1'b1; e.err = 8'd0;
    end else begin
      e.lrck = lr;
      e.data = e_mute ? 1'b0 : DATAIN;
      e.lock = e_lock;
      e.mute = e_mute;
      e.err  = 8'(e_err);
    end
    exp_q.push_back(e);
  endtask

  // One LRCK half: expectations at its edge, optional overrun flag at long_idx
  task automatic half(input int len, input bit err0, input bit lk, input bit mt, input int long_idx);
    for (int i = 0; i < len; i++) begin
      if (i == 0) begin
        e_lock = lk;
        e_mute = mt;
        if (err0) bump();
      end
      if (i == long_idx) begin
        e_lock = 1'b0;
        e_mute = 1'b1;
        bump();
      end
      cyc(1'b0, lvl);
    end
    lvl = ~lvl;
  endtask

  // From reset: 5 idle cycles, first rising edge, lock on edge 9, unmute on edge 10
  task automatic start_seq();
    e_lock = 1'b0;
    e_mute = 1'b1;
    repeat (5) cyc(1'b0, 1'b0);
    lvl = 1'b1;
    for (int h = 1; h <= 8; h++) half(32, 1'b0, 1'b0, 1'b1, -1);
    half(32, 1'b0, 1'b1, 1'b1, -1);
    half(32, 1'b0, 1'b1, 1'b0, -1);
  endtask

  initial begin
    RST = 1'b1; LRCK = 1'b0; DATAIN = 1'b0;
    e_lock = 1'b0; e_mute = 1'b1; e_err = 0; lvl = 1'b0;

    repeat (3) cyc(1'b1, 1'b0);

    // Clean stream, then one 31-cycle half while locked and the relock
    start_seq();
    half(32, 1'b0, 1'b1, 1'b0, -1);
    half(31, 1'b0, 1'b1, 1'b0, -1);
    half(32, 1'b1, 1'b0, 1'b1, -1);
    for (int h = 14; h <= 20; h++) half(32, 1'b0, 1'b0, 1'b1, -1);
    half(32, 1'b0, 1'b1, 1'b1, -1);
    half(32, 1'b0, 1'b1, 1'b0, -1);
    half(32, 1'b0, 1'b1, 1'b0, -1);

    // Reset in the middle of a locked, unmuted word
    e_lock = 1'b1; e_mute = 1'b0;
    repeat (10) cyc(1'b0, lvl);
    repeat (2) cyc(1'b1, 1'b0);
    e_err = 0;
    lvl = 1'b0;

    // Lock again, then hold LRCK high: single overrun error, no more while static
    start_seq();
    half(100, 1'b0, 1'b1, 1'b0, 32);

    // Reacquire to good=7 and end the next half short on a falling edge
    half(32, 1'b0, 1'b0, 1'b1, -1);
    for (int h = 1; h <= 6; h++) half(32, 1'b0, 1'b0, 1'b1, -1);
    half(31, 1'b0, 1'b0, 1'b1, -1);
    half(32, 1'b1, 1'b0, 1'b1, -1);

    // Alternating 31/33 halves: two errors per pair, counter saturates
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) half(31, 1'b0, 1'b0, 1'b1, -1);
      else            half(33, 1'b1, 1'b0, 1'b1, 32);
    end

    repeat (2) @(posedge BCK);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
